// File: rtl/tcdm_bank_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tcdm_bank_pipe
//  Purpose  : Bank-side stage of the TCDM interconnect. Inserts an optional
//             request register and an optional response register between the
//             interconnect slave port and one SRAM bank. Configuration changes
//             take effect only once the bank pipeline has drained.
//  Revision : 1.0 - initial release
// ============================================================================
module tcdm_bank_pipe #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // interconnect side
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    output logic                  data_gnt_o,
    output logic                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [ID_WIDTH-1:0]   data_r_ID_o,
    // SRAM side
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic                  mem_wen_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    // per-bank pipeline configuration
    input  logic                  enable_pipe_req_i,
    input  logic                  enable_pipe_resp_i
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Effective configuration; the raw enable inputs never steer the datapath.
    logic cfg_req_q,  cfg_req_d;
    logic cfg_resp_q, cfg_resp_d;

    logic w_cfg_match;
    logic w_pipe_empty;
    logic w_gnt;
    logic w_req_fire;

    // Request register
    logic                  req_vld_q;
    logic [ADDR_WIDTH-1:0] req_add_q;
    logic                  req_wen_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic [BE_WIDTH-1:0]   req_be_q;
    logic [ID_WIDTH-1:0]   req_id_q;

    // SRAM access tracking (SRAM data arrives the cycle after mem_req_o)
    logic                  mem_pend_q;
    logic [ID_WIDTH-1:0]   mem_id_q;
    logic [ID_WIDTH-1:0]   w_issue_id;

    // Response register
    logic                  resp_vld_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic [ID_WIDTH-1:0]   resp_id_q;

    assign w_cfg_match  = ({enable_pipe_req_i, enable_pipe_resp_i} == {cfg_req_q, cfg_resp_q});
    // No stage holds an access: nothing in the request register, no SRAM
    // access awaiting data and nothing in the response register.
    assign w_pipe_empty = ~req_vld_q & ~mem_pend_q & ~resp_vld_q;
    assign w_req_fire   = data_req_i & w_gnt;
    assign data_gnt_o   = w_gnt;

    // FSM state and effective configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cfg_req_q  <= 1'b0;
            cfg_resp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_req_q  <= cfg_req_d;
            cfg_resp_q <= cfg_resp_d;
        end
    end

    // FSM next state and grant: grant is withheld from the first cycle a
    // config mismatch is seen until the cycle after the pipeline empties.
    always_comb begin
        state_d    = state_q;
        cfg_req_d  = cfg_req_q;
        cfg_resp_d = cfg_resp_q;
        w_gnt      = 1'b0;
        case (state_q)
            RUN: begin
                if (w_cfg_match) begin
                    w_gnt = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The inputs may have reverted meanwhile; loading them is
                // then a no-op, but the drain is still completed.
                if (w_pipe_empty) begin
                    cfg_req_d  = enable_pipe_req_i;
                    cfg_resp_d = enable_pipe_resp_i;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Request register: captures a granted request when the request stage is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_vld_q   <= 1'b0;
            req_add_q   <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_id_q    <= '0;
        end else begin
            req_vld_q <= w_req_fire & cfg_req_q;
            if (w_req_fire && cfg_req_q) begin
                req_add_q   <= data_add_i;
                req_wen_q   <= data_wen_i;
                req_wdata_q <= data_wdata_i;
                req_be_q    <= data_be_i;
                req_id_q    <= data_ID_i;
            end
        end
    end

    // SRAM request mux: registered or pass-through path
    always_comb begin
        if (cfg_req_q) begin
            mem_req_o   = req_vld_q;
            mem_add_o   = req_add_q;
            mem_wen_o   = req_wen_q;
            mem_wdata_o = req_wdata_q;
            mem_be_o    = req_be_q;
            w_issue_id  = req_id_q;
        end else begin
            mem_req_o   = w_req_fire;
            mem_add_o   = data_add_i;
            mem_wen_o   = data_wen_i;
            mem_wdata_o = data_wdata_i;
            mem_be_o    = data_be_i;
            w_issue_id  = data_ID_i;
        end
    end

    // Track the access the SRAM is answering this cycle, with its ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pend_q <= 1'b0;
            mem_id_q   <= '0;
        end else begin
            mem_pend_q <= mem_req_o;
            if (mem_req_o) begin
                mem_id_q <= w_issue_id;
            end
        end
    end

    // Response register: holds SRAM data and ID for one extra cycle when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_id_q    <= '0;
        end else begin
            resp_vld_q <= mem_pend_q & cfg_resp_q;
            if (mem_pend_q && cfg_resp_q) begin
                resp_rdata_q <= mem_rdata_i;
                resp_id_q    <= mem_id_q;
            end
        end
    end

    // Response output mux; pass-through data is zeroed when no response is
    // pending so the output stays quiet in reset and idle cycles.
    always_comb begin
        if (cfg_resp_q) begin
            data_r_valid_o = resp_vld_q;
            data_r_rdata_o = resp_rdata_q;
            data_r_ID_o    = resp_id_q;
        end else begin
            data_r_valid_o = mem_pend_q;
            data_r_rdata_o = mem_pend_q ? mem_rdata_i : '0;
            data_r_ID_o    = mem_id_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcdm_bank_pipe
//  Purpose  : Directed self-checking bench for tcdm_bank_pipe with a simple
//             one-cycle-latency SRAM model and response/request loggers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_pipe;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = 4;
    localparam int ID_WIDTH   = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  data_req_i = 1'b0;
    logic [ADDR_WIDTH-1:0] data_add_i = '0;
    logic                  data_wen_i = 1'b0;
    logic [DATA_WIDTH-1:0] data_wdata_i = '0;
    logic [BE_WIDTH-1:0]   data_be_i = '0;
    logic [ID_WIDTH-1:0]   data_ID_i = '0;
    logic                  data_gnt_o;
    logic                  data_r_valid_o;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic [ID_WIDTH-1:0]   data_r_ID_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_add_o;
    logic                  mem_wen_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  enable_pipe_req_i = 1'b0;
    logic                  enable_pipe_resp_i = 1'b0;

    tcdm_bank_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_req_i         (data_req_i),
        .data_add_i         (data_add_i),
        .data_wen_i         (data_wen_i),
        .data_wdata_i       (data_wdata_i),
        .data_be_i          (data_be_i),
        .data_ID_i          (data_ID_i),
        .data_gnt_o         (data_gnt_o),
        .data_r_valid_o     (data_r_valid_o),
        .data_r_rdata_o     (data_r_rdata_o),
        .data_r_ID_o        (data_r_ID_o),
        .mem_req_o          (mem_req_o),
        .mem_add_o          (mem_add_o),
        .mem_wen_o          (mem_wen_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_be_o           (mem_be_o),
        .mem_rdata_i        (mem_rdata_i),
        .enable_pipe_req_i  (enable_pipe_req_i),
        .enable_pipe_resp_i (enable_pipe_resp_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one access per cycle, read data one cycle after request
    logic [DATA_WIDTH-1:0] sram [0:4095];
    logic [DATA_WIDTH-1:0] sram_rdata_q = '0;
    assign mem_rdata_i = sram_rdata_q;

    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_wen_o) begin
                sram_rdata_q <= sram[mem_add_o];
            end else begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (mem_be_o[b]) sram[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        int                    cyc;
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    typedef struct {
        int                    cyc;
        logic                  wen;
        logic [ADDR_WIDTH-1:0] add;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } mreq_t;

    rsp_t  rsp_q[$];
    mreq_t mreq_q[$];

    // Loggers sample mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (data_r_valid_o) rsp_q.push_back('{cyc, data_r_ID_o, data_r_rdata_o});
        if (mem_req_o)      mreq_q.push_back('{cyc, mem_wen_o, mem_add_o, mem_wdata_o, mem_be_o});
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input int idx, input int exp_cyc,
                             input logic [7:0] id, input logic [31:0] data, input bit chk_data);
        if (idx >= rsp_q.size()) begin
            check({tag, "_present"}, 64'(rsp_q.size()), 64'(idx + 1));
        end else begin
            check({tag, "_cyc"}, 64'(rsp_q[idx].cyc), 64'(exp_cyc));
            check({tag, "_id"}, 64'(rsp_q[idx].id), 64'(id));
            if (chk_data) check({tag, "_data"}, 64'(rsp_q[idx].data), 64'(data));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [11:0] add, input logic wen,
                         input logic [31:0] wd, input logic [3:0] be, input logic [7:0] id);
        data_req_i   = req;
        data_add_i   = add;
        data_wen_i   = wen;
        data_wdata_i = wd;
        data_be_i    = be;
        data_ID_i    = id;
    endtask

    task automatic idle();
        drive(1'b0, 12'h0, 1'b1, 32'h0, 4'h0, 8'h0);
    endtask

    task automatic set_cfg(input logic rq, input logic rs);
        enable_pipe_req_i  = rq;
        enable_pipe_resp_i = rs;
        repeat (4) tick();
    endtask

    int c0;
    int g;

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
        sram[12'h010] = 32'hDEADBEEF;
        sram[12'h3FF] = 32'hAAAAAAAA;
        for (int i = 0; i < 4; i++) sram[12'h021 + i] = 32'hC0DE0000 + 32'(i + 1);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(data_gnt_o), 64'd1);
        check("rst_memreq", 64'(mem_req_o), 64'd0);
        check("rst_rvalid", 64'(data_r_valid_o), 64'd0);
        check("rst_rdata", 64'(data_r_rdata_o), 64'd0);
        check("rst_rid", 64'(data_r_ID_o), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // ---------------- config 00: single read ----------------
        rsp_q.delete(); mreq_q.delete();
        c0 = cyc;
        drive(1'b1, 12'h010, 1'b1, 32'h0, 4'hF, 8'h04);
        @(negedge clk);
        check("c00_gnt", 64'(data_gnt_o), 64'd1);
        tick(); idle();
        repeat (4) tick();
        check("c00_nreq", 64'(mreq_q.size()), 64'd1);
        if (mreq_q.size() > 0) check("c00_req_cyc", 64'(mreq_q[0].cyc - c0), 64'd0);
        check("c00_nrsp", 64'(rsp_q.size()), 64'd1);
        check_rsp("c00_rsp", 0, c0 + 1, 8'h04, 32'hDEADBEEF, 1'b1);

        // ---------------- config 11: 4 back-to-back reads ----------------
        set_cfg(1'b1, 1'b1);
        rsp_q.delete(); mreq_q.delete();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'h021 + 12'(i), 1'b1, 32'h0, 4'hF, 8'(i + 1));
            @(negedge clk);
            check($sformatf("c11_gnt%0d", i), 64'(data_gnt_o), 64'd1);
            tick();
        end
        idle();
        repeat (8) tick();
        check("c11_nreq", 64'(mreq_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < mreq_q.size(); i++)
            check($sformatf("c11_req%0d_cyc", i), 64'(mreq_q[i].cyc - c0), 64'(i + 1));
        check("c11_nrsp", 64'(rsp_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check_rsp($sformatf("c11_rsp%0d", i), i, c0 + 3 + i, 8'(i + 1), 32'hC0DE0000 + 32'(i + 1), 1'b1);

        // ---------------- config 10: write then read-back ----------------
        set_cfg(1'b1, 1'b0);
        rsp_q.delete(); mreq_q.delete();
        c0 = cyc;
        drive(1'b1, 12'h3FF, 1'b0, 32'h12345678, 4'b0011, 8'h55);
        tick(); idle();
        repeat (4) tick();
        check("c10_nreq", 64'(mreq_q.size()), 64'd1);
        if (mreq_q.size() > 0) begin
            check("c10_req_cyc", 64'(mreq_q[0].cyc - c0), 64'd1);
            check("c10_req_wen", 64'(mreq_q[0].wen), 64'd0);
            check("c10_req_add", 64'(mreq_q[0].add), 64'h3FF);
            check("c10_req_be", 64'(mreq_q[0].be), 64'h3);
            check("c10_req_wdata", 64'(mreq_q[0].wdata), 64'h12345678);
        end
        check_rsp("c10_wrsp", 0, c0 + 2, 8'h55, 32'h0, 1'b0);
        rsp_q.delete();
        c0 = cyc;
        drive(1'b1, 12'h3FF, 1'b1, 32'h0, 4'hF, 8'h56);
        tick(); idle();
        repeat (4) tick();
        check_rsp("c10_rdback", 0, c0 + 2, 8'h56, 32'hAAAA5678, 1'b1);

        // ---------------- switch 00 -> 11 with two reads in flight ----------------
        set_cfg(1'b0, 1'b0);
        rsp_q.delete(); mreq_q.delete();
        c0 = cyc;
        drive(1'b1, 12'h010, 1'b1, 32'h0, 4'hF, 8'h11);
        tick();
        drive(1'b1, 12'h021, 1'b1, 32'h0, 4'hF, 8'h12);
        tick();
        enable_pipe_req_i  = 1'b1;
        enable_pipe_resp_i = 1'b1;
        g = -1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 12'h022, 1'b1, 32'h0, 4'hF, 8'h13);
            @(negedge clk);
            if (data_gnt_o) begin
                g = cyc;
                break;
            end
            tick();
        end
        tick(); idle();
        repeat (6) tick();
        check("sw_gnt_cyc", 64'(g - c0), 64'd4);
        check("sw_nrsp", 64'(rsp_q.size()), 64'd3);
        check_rsp("sw_rsp0", 0, c0 + 1, 8'h11, 32'hDEADBEEF, 1'b1);
        check_rsp("sw_rsp1", 1, c0 + 2, 8'h12, 32'hC0DE0001, 1'b1);
        check_rsp("sw_rsp2", 2, g + 3, 8'h13, 32'hC0DE0002, 1'b1);

        // ---------------- toggle then revert during drain (cfg 11) ----------------
        rsp_q.delete(); mreq_q.delete();
        c0 = cyc;
        drive(1'b1, 12'h023, 1'b1, 32'h0, 4'hF, 8'h21);
        tick();
        drive(1'b1, 12'h024, 1'b1, 32'h0, 4'hF, 8'h22);
        tick();
        enable_pipe_req_i  = 1'b0;
        enable_pipe_resp_i = 1'b0;
        drive(1'b1, 12'h010, 1'b1, 32'h0, 4'hF, 8'h23);
        @(negedge clk);
        check("rv_gnt_mismatch", 64'(data_gnt_o), 64'd0);
        tick();
        enable_pipe_req_i  = 1'b1;
        enable_pipe_resp_i = 1'b1;
        g = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (data_gnt_o) begin
                g = cyc;
                break;
            end
            tick();
        end
        tick(); idle();
        repeat (6) tick();
        check("rv_gnt_cyc", 64'(g - c0), 64'd6);
        check("rv_nrsp", 64'(rsp_q.size()), 64'd3);
        check_rsp("rv_rsp0", 0, c0 + 3, 8'h21, 32'hC0DE0003, 1'b1);
        check_rsp("rv_rsp1", 1, c0 + 4, 8'h22, 32'hC0DE0004, 1'b1);
        check_rsp("rv_rsp2", 2, g + 3, 8'h23, 32'hDEADBEEF, 1'b1);

        // ---------------- reset mid-operation (cfg 11) ----------------
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 12'h021, 1'b1, 32'h0, 4'hF, 8'(8'h31 + i));
            tick();
        end
        // now req_vld_q (third grant) and resp_vld_q (first read) are both set
        idle();
        enable_pipe_req_i  = 1'b0;
        enable_pipe_resp_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_rvalid", 64'(data_r_valid_o), 64'd0);
        check("mrst_memreq", 64'(mem_req_o), 64'd0);
        check("mrst_rdata", 64'(data_r_rdata_o), 64'd0);
        check("mrst_rid", 64'(data_r_ID_o), 64'd0);
        check("mrst_gnt", 64'(data_gnt_o), 64'd1);
        rsp_q.delete(); mreq_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("mrst_no_rsp", 64'(rsp_q.size()), 64'd0);
        check("mrst_no_req", 64'(mreq_q.size()), 64'd0);
        c0 = cyc;
        drive(1'b1, 12'h010, 1'b1, 32'h0, 4'hF, 8'h40);
        tick(); idle();
        repeat (4) tick();
        check("mrst_nrsp", 64'(rsp_q.size()), 64'd1);
        check_rsp("mrst_rsp", 0, c0 + 1, 8'h40, 32'hDEADBEEF, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
